// File: rtl/id_ex_stage_reg.sv
// id_ex_stage_reg: ID->EX pipeline register with operand forwarding and stall watchdog (optional perf counters via ID_EX_PERF_CNT_EN).
package id_ex_pkg;
  typedef enum logic [3:0] {
    OP_NO_OP    = 4'd0,
    OP_COMP     = 4'd1,
    OP_COMP_IMM = 4'd2,
    OP_LOAD     = 4'd3,
    OP_STORE    = 4'd4,
    OP_BRANCH   = 4'd5,
    OP_JAL      = 4'd6,
    OP_JALR     = 4'd7,
    OP_LUI      = 4'd8,
    OP_AUIPC    = 4'd9
  } decoded_opcode;
endpackage

module id_ex_stage_reg
  import id_ex_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int MAX_STALL  = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_i,
  input  logic                  clear_i,
  input  decoded_opcode         instr_type_i,
  input  logic [DATA_WIDTH-1:0] rs1_data_i,
  input  logic [DATA_WIDTH-1:0] rs2_data_i,
  input  logic [DATA_WIDTH-1:0] imm_i,
  input  logic [ADDR_WIDTH-1:0] write_addr_i,
  input  logic                  write_en_i,
  input  logic                  fwrd_opA_type1_i,
  input  logic                  fwrd_opA_type2_i,
  input  logic                  fwrd_opB_type1_i,
  input  logic                  fwrd_opB_type2_i,
  input  logic [DATA_WIDTH-1:0] ex_result_i,
  input  logic [DATA_WIDTH-1:0] wb_result_i,
  output decoded_opcode         instr_type_o,
  output logic [DATA_WIDTH-1:0] opA_o,
  output logic [DATA_WIDTH-1:0] opB_o,
  output logic [DATA_WIDTH-1:0] imm_o,
  output logic [ADDR_WIDTH-1:0] write_addr_o,
  output logic                  write_en_o,
  output logic                  valid_o,
  output logic                  stall_timeout_o,
  output logic [31:0]           perf_stall_cnt_o,
  output logic [31:0]           perf_clear_cnt_o
);
  localparam int CW = $clog2(MAX_STALL + 1);
  decoded_opcode         r_instr_type;
  logic [DATA_WIDTH-1:0] r_opa, r_opb, r_imm;
  logic [ADDR_WIDTH-1:0] r_write_addr;
  logic                  r_write_en, r_valid, r_timeout;
  logic [CW-1:0]         r_stall_cnt;
  logic [DATA_WIDTH-1:0] w_sel_a, w_sel_b;
  assign w_sel_a = fwrd_opA_type1_i ? ex_result_i : fwrd_opA_type2_i ? wb_result_i : rs1_data_i;
  assign w_sel_b = fwrd_opB_type1_i ? ex_result_i : fwrd_opB_type2_i ? wb_result_i : rs2_data_i;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_instr_type <= OP_NO_OP;
      r_opa        <= '0;
      r_opb        <= '0;
      r_imm        <= '0;
      r_write_addr <= '0;
      r_write_en   <= 1'b0;
      r_valid      <= 1'b0;
      r_timeout    <= 1'b0;
      r_stall_cnt  <= '0;
    end else if (clear_i) begin
      r_instr_type <= OP_NO_OP;
      r_write_en   <= 1'b0;
      r_valid      <= 1'b0;
      r_stall_cnt  <= '0;
    end else if (stall_i) begin
      // timeout fires on the stall edge that finds the counter already saturated
      if (r_stall_cnt == CW'(MAX_STALL)) r_timeout <= 1'b1;
      else r_stall_cnt <= r_stall_cnt + 1'b1;
    end else begin
      r_instr_type <= instr_type_i;
      r_opa        <= w_sel_a;
      r_opb        <= w_sel_b;
      r_imm        <= imm_i;
      r_write_addr <= write_addr_i;
      r_write_en   <= write_en_i;
      r_valid      <= instr_type_i != OP_NO_OP;
      r_stall_cnt  <= '0;
    end
  end
  assign instr_type_o    = r_instr_type;
  assign opA_o           = r_opa;
  assign opB_o           = r_opb;
  assign imm_o           = r_imm;
  assign write_addr_o    = r_write_addr;
  assign write_en_o      = r_write_en;
  assign valid_o         = r_valid;
  assign stall_timeout_o = r_timeout;
`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] r_perf_stall, r_perf_clear;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_stall <= '0;
      r_perf_clear <= '0;
    end else if (clear_i) r_perf_clear <= r_perf_clear + 32'd1;
    else if (stall_i) r_perf_stall <= r_perf_stall + 32'd1;
  end
  assign perf_stall_cnt_o = r_perf_stall;
  assign perf_clear_cnt_o = r_perf_clear;
`else
  assign perf_stall_cnt_o = '0;
  assign perf_clear_cnt_o = '0;
`endif
endmodule

// File: tb/tb_id_ex_stage_reg.sv
// tb_id_ex_stage_reg: directed scoreboard bench for id_ex_stage_reg.
module tb_id_ex_stage_reg;
  import id_ex_pkg::*;
  logic clk = 1'b0, rst, stall_i, clear_i, write_en_i;
  logic fa1, fa2, fb1, fb2;
  decoded_opcode instr_type_i, instr_type_o;
  logic [31:0] rs1_data_i, rs2_data_i, imm_i, ex_result_i, wb_result_i;
  logic [31:0] opA_o, opB_o, imm_o, perf_stall_cnt_o, perf_clear_cnt_o;
  logic [4:0] write_addr_i, write_addr_o;
  logic write_en_o, valid_o, stall_timeout_o;
  int checks = 0, errors = 0;
  typedef struct {
    decoded_opcode it;
    logic [31:0] a, b, imm;
    logic [4:0] wa;
    logic we, v, to;
  } exp_t;
  exp_t m, sb[$];
  int wd = 0;
  logic [31:0] ps = 0, pc = 0;
  always #5 clk = ~clk;
  id_ex_stage_reg dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .clear_i(clear_i),
    .instr_type_i(instr_type_i), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
    .imm_i(imm_i), .write_addr_i(write_addr_i), .write_en_i(write_en_i),
    .fwrd_opA_type1_i(fa1), .fwrd_opA_type2_i(fa2),
    .fwrd_opB_type1_i(fb1), .fwrd_opB_type2_i(fb2),
    .ex_result_i(ex_result_i), .wb_result_i(wb_result_i),
    .instr_type_o(instr_type_o), .opA_o(opA_o), .opB_o(opB_o), .imm_o(imm_o),
    .write_addr_o(write_addr_o), .write_en_o(write_en_o), .valid_o(valid_o),
    .stall_timeout_o(stall_timeout_o), .perf_stall_cnt_o(perf_stall_cnt_o),
    .perf_clear_cnt_o(perf_clear_cnt_o)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step(input string tag);
    exp_t e;
    if (rst) begin
      m = '{OP_NO_OP, 0, 0, 0, 0, 0, 0, 0};
      wd = 0; ps = 0; pc = 0;
    end else if (clear_i) begin
      m.it = OP_NO_OP; m.we = 0; m.v = 0; wd = 0; pc++;
    end else if (stall_i) begin
      if (wd == 15) m.to = 1; else wd++;
      ps++;
    end else begin
      m.it  = instr_type_i;
      m.a   = fa1 ? ex_result_i : fa2 ? wb_result_i : rs1_data_i;
      m.b   = fb1 ? ex_result_i : fb2 ? wb_result_i : rs2_data_i;
      m.imm = imm_i; m.wa = write_addr_i; m.we = write_en_i;
      m.v   = instr_type_i != OP_NO_OP; wd = 0;
    end
    sb.push_back(m);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, ".opA"}, opA_o, e.a);
    chk({tag, ".opB"}, opB_o, e.b);
    chk({tag, ".imm_wa"}, {imm_o[26:0], write_addr_o}, {e.imm[26:0], e.wa});
    chk({tag, ".ctrl"}, {26'd0, 32'(instr_type_o) , write_en_o, valid_o}, {26'd0, 32'(e.it), e.we, e.v});
    chk({tag, ".timeout"}, 32'(stall_timeout_o), 32'(e.to));
  endtask
  task automatic load(input decoded_opcode it, input logic [31:0] a, input logic [31:0] b);
    stall_i = 0; clear_i = 0; instr_type_i = it; rs1_data_i = a; rs2_data_i = b;
    fa1 = 0; fa2 = 0; fb1 = 0; fb2 = 0;
  endtask
  initial begin
    rst = 1; stall_i = 0; clear_i = 0; write_en_i = 1; write_addr_i = 5'd5; imm_i = 32'h7;
    instr_type_i = OP_COMP; rs1_data_i = 32'h11; rs2_data_i = 32'h22;
    ex_result_i = 32'hAA; wb_result_i = 32'hBB; fa1 = 1; fa2 = 1; fb1 = 1; fb2 = 1;
    step("reset0");
    step("reset1");
    chk("reset_valid", 32'(valid_o), 0);
    chk("reset_opA", opA_o, 0);
    rst = 0;
    load(OP_COMP, 32'h11, 32'h22);
    step("load");
    chk("load_opA_const", opA_o, 32'h11);
    chk("load_wa_const", 32'(write_addr_o), 5);
    chk("load_valid_const", 32'(valid_o), 1);
    fa1 = 1; fb2 = 1;
    step("fwd_ex_wb");
    chk("fwd_opA_const", opA_o, 32'hAA);
    chk("fwd_opB_const", opB_o, 32'hBB);
    fa1 = 1; fa2 = 1; fb1 = 1; fb2 = 1; ex_result_i = 32'hC0DE; wb_result_i = 32'hBEEF;
    step("fwd_both_sel");
    chk("fwd_type1_wins", opA_o, 32'hC0DE);
    load(OP_LOAD, 32'h11, 32'h22); write_addr_i = 5'd9; imm_i = 32'h123; write_en_i = 1;
    step("load2");
    stall_i = 1; rs1_data_i = 32'h33; rs2_data_i = 32'h44; fa1 = 1; fb2 = 1;
    imm_i = 32'h456; write_addr_i = 5'd3; instr_type_i = OP_STORE; write_en_i = 0;
    for (int i = 0; i < 3; i++) step("stall_hold");
    chk("stall_opA_const", opA_o, 32'h11);
    chk("stall_opB_const", opB_o, 32'h22);
    load(OP_STORE, 32'h33, 32'h44);
    step("stall_release");
    chk("release_opB_const", opB_o, 32'h44);
    instr_type_i = OP_NO_OP;
    step("load_nop");
    chk("nop_valid", 32'(valid_o), 0);
    load(OP_BRANCH, 32'h55, 32'h66); write_en_i = 1;
    step("load3");
    stall_i = 1;
    for (int i = 0; i < 10; i++) step("pre_clear_stall");
    clear_i = 1;
    step("clear_stall");
    chk("clear_valid", 32'(valid_o), 0);
    chk("clear_data_held", opA_o, 32'h55);
    clear_i = 0;
    for (int i = 0; i < 15; i++) step("wd_stall");
    chk("wd_15_no_timeout", 32'(stall_timeout_o), 0);
    step("wd_stall16");
    chk("wd_16_timeout", 32'(stall_timeout_o), 1);
    step("wd_stall17");
`ifdef ID_EX_PERF_CNT_EN
    chk("perf_stall", perf_stall_cnt_o, ps);
    chk("perf_clear", perf_clear_cnt_o, pc);
`else
    chk("perf_stall_tied", perf_stall_cnt_o, 0);
    chk("perf_clear_tied", perf_clear_cnt_o, 0);
`endif
    load(OP_JAL, 32'h77, 32'h88);
    step("wd_release");
    chk("wd_sticky", 32'(stall_timeout_o), 1);
    rst = 1; stall_i = 1; clear_i = 1;
    step("reset_again");
    chk("reset_perf", perf_stall_cnt_o | perf_clear_cnt_o, 0);
    rst = 0; stall_i = 1; clear_i = 0;
    for (int i = 0; i < 16; i++) step("wd2_stall");
`ifdef ID_EX_PERF_CNT_EN
    chk("perf_stall_16", perf_stall_cnt_o, 16);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
